ex_stage_mc: RTL and testbench

// - Parametrised multi-cycle execute stage; sits between ID/EX and EX/MEM.
// - Single-cycle ALU ops: logic, shift, add/sub, set-less-than.
// - Optional iterative unsigned divider holds the pipeline through stall_req_o.
// - Results are registered here, so this block also forms the EX/MEM boundary.

---
 rtl/ex_stage_mc.sv | 162 ++++++++++++++++
 tb/tb_ex_stage_mc.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ex_stage_mc.sv
// Multi-cycle execute stage with a registered EX/MEM boundary.
// Optional iterative unsigned divider (DIVU) is enabled by defining EX_DIV_EN.
module ex_stage_mc #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [3:0]        aluop_i,
   input  logic [DATA_W-1:0] reg1_data_i,
   input  logic [DATA_W-1:0] reg2_data_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   input  logic              rd_write_i,
   input  logic              stall_i,
   output logic              stall_req_o,
   output logic              out_valid,
   output logic [ADDR_W-1:0] rd_addr_o,
   output logic              rd_write_o,
   output logic [DATA_W-1:0] write_data_o,
   output logic [DATA_W-1:0] rem_o
);
   localparam int SH_W = $clog2(DATA_W);

   localparam logic [3:0] OP_OR   = 4'd0;
   localparam logic [3:0] OP_AND  = 4'd1;
   localparam logic [3:0] OP_XOR  = 4'd2;
   localparam logic [3:0] OP_NOR  = 4'd3;
   localparam logic [3:0] OP_SLL  = 4'd4;
   localparam logic [3:0] OP_SRL  = 4'd5;
   localparam logic [3:0] OP_SRA  = 4'd6;
   localparam logic [3:0] OP_ADD  = 4'd7;
   localparam logic [3:0] OP_SUB  = 4'd8;
   localparam logic [3:0] OP_SLT  = 4'd9;
   localparam logic [3:0] OP_DIVU = 4'd10;

   logic [SH_W-1:0]   sh;
   logic [DATA_W-1:0] alu_res, alu_rem;
   logic              op_wr;

   assign sh = reg2_data_i[SH_W-1:0];

   always_comb begin
      alu_res = '0;
      alu_rem = '0;
      op_wr   = 1'b1;
      case (aluop_i)
         OP_OR:  alu_res = reg1_data_i | reg2_data_i;
         OP_AND: alu_res = reg1_data_i & reg2_data_i;
         OP_XOR: alu_res = reg1_data_i ^ reg2_data_i;
         OP_NOR: alu_res = ~(reg1_data_i | reg2_data_i);
         OP_SLL: alu_res = reg1_data_i << sh;
         OP_SRL: alu_res = reg1_data_i >> sh;
         OP_SRA: alu_res = $signed(reg1_data_i) >>> sh;
         OP_ADD: alu_res = reg1_data_i + reg2_data_i;
         OP_SUB: alu_res = reg1_data_i - reg2_data_i;
         OP_SLT: alu_res = {{(DATA_W-1){1'b0}}, $signed(reg1_data_i) < $signed(reg2_data_i)};
`ifdef EX_DIV_EN
         // Only the divide-by-zero case resolves here; real divides go to the FSM.
         OP_DIVU: begin
            alu_res = '1;
            alu_rem = reg1_data_i;
         end
`endif
         default: op_wr = 1'b0;
      endcase
   end

`ifdef EX_DIV_EN
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state, state_nx;

   logic [DATA_W-1:0] quo, rmd, dvsr, nrmd;
   logic [DATA_W:0]   part;
   logic              part_ge;
   logic [SH_W-1:0]   cnt;
   logic [ADDR_W-1:0] div_rd;
   logic              div_wr;
   logic              div_start;

   assign div_start   = (state == IDLE) & in_valid & (aluop_i == OP_DIVU) & (reg2_data_i != '0);
   assign stall_req_o = stall_i | (state == BUSY) | div_start;

   // Restoring step: shift next dividend bit into the partial remainder.
   assign part    = {rmd, quo[DATA_W-1]};
   assign part_ge = part >= {1'b0, dvsr};
   assign nrmd    = part_ge ? (part[DATA_W-1:0] - dvsr) : part[DATA_W-1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (!stall_i) begin
         case (state)
            IDLE:    if (div_start) state_nx = BUSY;
            BUSY:    if (cnt == SH_W'(DATA_W-1)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         quo    <= '0;
         rmd    <= '0;
         dvsr   <= '0;
         cnt    <= '0;
         div_rd <= '0;
         div_wr <= 1'b0;
      end else if (!stall_i) begin
         if (div_start) begin
            quo    <= reg1_data_i;
            rmd    <= '0;
            dvsr   <= reg2_data_i;
            cnt    <= '0;
            div_rd <= rd_addr_i;
            div_wr <= rd_write_i;
         end else if (state == BUSY) begin
            quo <= {quo[DATA_W-2:0], part_ge};
            rmd <= nrmd;
            cnt <= cnt + 1'b1;
         end
      end
   end
`else
   assign stall_req_o = stall_i;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid    <= 1'b0;
         rd_addr_o    <= '0;
         rd_write_o   <= 1'b0;
         write_data_o <= '0;
         rem_o        <= '0;
      end else if (!stall_i) begin
`ifdef EX_DIV_EN
         if (state == DONE) begin
            out_valid    <= 1'b1;
            rd_addr_o    <= div_rd;
            rd_write_o   <= div_wr;
            write_data_o <= quo;
            rem_o        <= rmd;
         end else if (state == BUSY || div_start) begin
            out_valid  <= 1'b0;
            rd_write_o <= 1'b0;
         end else
`endif
         begin
            out_valid    <= in_valid;
            rd_addr_o    <= rd_addr_i;
            rd_write_o   <= in_valid & rd_write_i & op_wr;
            write_data_o <= alu_res;
            rem_o        <= alu_rem;
         end
      end
   end
endmodule

// File: tb/tb_ex_stage_mc.sv
// Directed bench for ex_stage_mc (DATA_W=32); divider vectors run when EX_DIV_EN is defined.
module tb_ex_stage_mc;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [3:0]  aluop = 4'd15;
   logic [31:0] a = '0, b = '0;
   logic [4:0]  rd = '0;
   logic        wr = 1'b0;
   logic        stall = 1'b0;
   logic        stall_req, out_valid, rd_write_o;
   logic [4:0]  rd_addr_o;
   logic [31:0] write_data_o, rem_o;

   int n_chk  = 0;
   int n_pass = 0;

   ex_stage_mc #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .aluop_i(aluop),
      .reg1_data_i(a), .reg2_data_i(b), .rd_addr_i(rd), .rd_write_i(wr),
      .stall_i(stall), .stall_req_o(stall_req), .out_valid(out_valid),
      .rd_addr_o(rd_addr_o), .rd_write_o(rd_write_o),
      .write_data_o(write_data_o), .rem_o(rem_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [4:0] r, input logic w,
                          input logic [31:0] d, input logic [31:0] m);
      chk({tag, ".valid"}, 32'(out_valid), 32'(v));
      chk({tag, ".rd"},    32'(rd_addr_o), 32'(r));
      chk({tag, ".wr"},    32'(rd_write_o), 32'(w));
      chk({tag, ".data"},  write_data_o, d);
      chk({tag, ".rem"},   rem_o, m);
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] r, input logic w);
      in_valid = 1'b1; aluop = op; a = x; b = y; rd = r; wr = w;
   endtask

   task automatic step;
      @(posedge clk); #1;
   endtask

`ifdef EX_DIV_EN
   // Counts edges from the accepting cycle until out_valid shows, bounded.
   task automatic run_div(input string tag, input int stall_at, input int exp_edges);
      int n;
      drive(4'd10, 32'd100, 32'd7, 5'd9, 1'b1);
      chk({tag, ".req0"}, 32'(stall_req), 32'd1);
      n = 0;
      while (!out_valid && n < 200) begin
         if (n == stall_at) begin
            stall = 1'b1;
            step; n++;
            chk({tag, ".frz_req"}, 32'(stall_req), 32'd1);
            chk({tag, ".frz_v"},   32'(out_valid), 32'd0);
            step; n++;
            step; n++;
            stall = 1'b0;
         end else begin
            if (!stall_req) in_valid = 1'b0;  // DONE cycle: upstream moves on
            step; n++;
         end
      end
      chk({tag, ".edges"}, 32'(n), 32'(exp_edges));
      chk_out(tag, 1'b1, 5'd9, 1'b1, 32'd14, 32'd2);
      step;
      chk({tag, ".pulse"}, 32'(out_valid), 32'd0);
   endtask
`endif

   initial begin
      int n;
      #12;
      chk_out("reset", 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
      chk("reset.req", 32'(stall_req), 32'd0);
      rst = 1'b1;
      step;

      drive(4'd0, 32'h00FF00F0, 32'h0F0000FF, 5'd3, 1'b1); step;
      chk_out("or", 1'b1, 5'd3, 1'b1, 32'h0FFF00FF, 32'd0);
      drive(4'd1, 32'hF0F0FFFF, 32'h0FF00F0F, 5'd4, 1'b1); step;
      chk("and", write_data_o, 32'h00F00F0F);
      drive(4'd2, 32'hFFFF0000, 32'h0F0F0F0F, 5'd5, 1'b1); step;
      chk("xor", write_data_o, 32'hF0F00F0F);
      drive(4'd3, 32'h0000FFFF, 32'h00FF0000, 5'd6, 1'b1); step;
      chk("nor", write_data_o, 32'hFF000000);
      drive(4'd4, 32'h00000001, 32'h00000024, 5'd7, 1'b1); step;
      chk("sll_mask", write_data_o, 32'h00000010);
      drive(4'd5, 32'h80000000, 32'd4, 5'd8, 1'b1); step;
      chk("srl", write_data_o, 32'h08000000);
      drive(4'd6, 32'h80000000, 32'd4, 5'd8, 1'b1); step;
      chk("sra", write_data_o, 32'hF8000000);
      drive(4'd7, 32'hFFFFFFFF, 32'd2, 5'd1, 1'b1); step;
      chk("add_wrap", write_data_o, 32'h00000001);
      drive(4'd8, 32'd0, 32'd1, 5'd1, 1'b1); step;
      chk("sub_wrap", write_data_o, 32'hFFFFFFFF);
      drive(4'd9, 32'hFFFFFFFF, 32'd1, 5'd2, 1'b1); step;
      chk_out("slt_neg", 1'b1, 5'd2, 1'b1, 32'd1, 32'd0);
      drive(4'd9, 32'd1, 32'hFFFFFFFF, 5'd2, 1'b1); step;
      chk("slt_pos", write_data_o, 32'd0);
      drive(4'd15, 32'd5, 32'd6, 5'd10, 1'b1); step;
      chk_out("nop", 1'b1, 5'd10, 1'b0, 32'd0, 32'd0);
      drive(4'd7, 32'd5, 32'd6, 5'd11, 1'b0); step;
      chk_out("nowr", 1'b1, 5'd11, 1'b0, 32'd11, 32'd0);
      drive(4'd7, 32'd5, 32'd6, 5'd12, 1'b1); in_valid = 1'b0; step;
      chk("inv.valid", 32'(out_valid), 32'd0);
      chk("inv.wr", 32'(rd_write_o), 32'd0);

      // Downstream stall freezes outputs, then the held op lands.
      drive(4'd0, 32'h00FF00F0, 32'h0F0000FF, 5'd3, 1'b1); step;
      drive(4'd7, 32'd10, 32'd20, 5'd13, 1'b1); stall = 1'b1;
      chk("stall.req", 32'(stall_req), 32'd1);
      step; step;
      chk_out("stall_hold", 1'b1, 5'd3, 1'b1, 32'h0FFF00FF, 32'd0);
      stall = 1'b0; step;
      chk_out("stall_rel", 1'b1, 5'd13, 1'b1, 32'd30, 32'd0);

`ifdef EX_DIV_EN
      drive(4'd10, 32'd5, 32'd0, 5'd14, 1'b1);
      chk("div0.req", 32'(stall_req), 32'd0);
      step;
      chk_out("div0", 1'b1, 5'd14, 1'b1, 32'hFFFFFFFF, 32'd5);

      // stall_req_o high for 33 sampled cycles, then the result pulse
      drive(4'd10, 32'd100, 32'd7, 5'd9, 1'b1);
      n = 0;
      while (stall_req && n < 100) begin step; n++; end
      chk("divu.req_cycles", 32'(n), 32'd33);
      chk("divu.done_v", 32'(out_valid), 32'd0);
      step;
      chk_out("divu", 1'b1, 5'd9, 1'b1, 32'd14, 32'd2);
      in_valid = 1'b0; step;
      chk("divu.pulse", 32'(out_valid), 32'd0);

      run_div("divu_nostall", -1, 34);
      run_div("divu_stall", 10, 37);

      drive(4'd10, 32'd100, 32'd7, 5'd9, 1'b1); step;
      in_valid = 1'b0;
      repeat (5) step;
`else
      drive(4'd10, 32'd5, 32'd0, 5'd14, 1'b1);
      chk("divu_off.req", 32'(stall_req), 32'd0);
      step;
      chk_out("divu_off", 1'b1, 5'd14, 1'b0, 32'd0, 32'd0);
      drive(4'd10, 32'd100, 32'd7, 5'd9, 1'b1);
      chk("divu_off.req2", 32'(stall_req), 32'd0);
      step;
      chk_out("divu_off2", 1'b1, 5'd9, 1'b0, 32'd0, 32'd0);
      drive(4'd7, 32'd4, 32'd4, 5'd9, 1'b1); step;
      in_valid = 1'b0;
`endif
      // Asynchronous reset mid-cycle clears outputs without a clock edge.
      #2 rst = 1'b0;
      #1;
      chk_out("arst", 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
      chk("arst.req", 32'(stall_req), 32'd0);
      @(negedge clk); rst = 1'b1;
      step;
      drive(4'd7, 32'd1, 32'd2, 5'd1, 1'b1); step;
      chk_out("post_rst_add", 1'b1, 5'd1, 1'b1, 32'd3, 32'd0);
      in_valid = 1'b0;
      step;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
